enemy_ai: RTL and testbench

- Parametrised enemy behaviour engine for the punch-out game; successor to the fixed three-position enemy controller/datapath pair.
- Roams across NUM_LANES screen lanes on a mode-dependent tick and switches calm/aggressive from health.
- Attacks every N moves with a windup → punch → recover sequence, and goes dead at zero health.
- Drives sprite coordinates, handshakes redraws with the VGA drawer, and pulses the LFSR for fresh random lanes.

---
 rtl/enemy_pkg.sv | 22 ++
 rtl/enemy_ai_tick_gen.sv | 29 ++
 rtl/enemy_ai.sv | 193 +++++++++++++++++++
 tb/tb_enemy_ai.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy behaviour engine: FSM state codes, mode
// encoding and the lane-to-screen-x mapping.
package enemy_pkg;

    localparam logic [2:0] ST_MOVE    = 3'd0;
    localparam logic [2:0] ST_WINDUP  = 3'd1;
    localparam logic [2:0] ST_PUNCH   = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_DEAD    = 3'd4;

    typedef enum logic {
        MODE_CALM = 1'b0,
        MODE_AGGR = 1'b1
    } mode_t;

    localparam int TICK_W = 28;

    function automatic logic [7:0] lane_to_x(input int lane_idx, input int base, input int step);
        return 8'(base + lane_idx * step);
    endfunction

endpackage

// File: rtl/enemy_ai_tick_gen.sv
// Reloadable down-counter; emits a one-cycle tick at terminal count zero and
// reloads from the period presented on that same cycle.
module tick_gen #(
    parameter int RESET_LOAD = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [27:0] period,
    output logic        tick
);

    logic [27:0] count;

    assign tick = enable && (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 28'(RESET_LOAD);
        end else if (enable) begin
            if (count == '0) begin
                count <= period;
            end else begin
                count <= count - 28'd1;
            end
        end
    end

endmodule

// File: rtl/enemy_ai.sv
// Enemy behaviour engine: lane roaming, periodic attack sequence, death, and
// the redraw handshake with the VGA drawer.
//
// state   | meaning
// MOVE    | roaming; each tick hops lanes or starts an attack
// WINDUP  | telegraphing the punch for WINDUP_LEN ticks
// PUNCH   | punch live until hit_ack or PUNCH_LEN ticks
// RECOVER | one tick of cooldown before roaming again
// DEAD    | health reached zero; sticky until reset
module enemy_ai #(
    parameter int NUM_LANES    = 3,
    parameter int LANE_W       = 2,
    parameter int HEALTH_W     = 4,
    parameter int AGGRO_THRESH = 6,
    parameter int CALM_TICKS   = 100_000_000,
    parameter int AGGR_TICKS   = 50_000_000,
    parameter int CALM_MOVES   = 4,
    parameter int AGGR_MOVES   = 2,
    parameter int WINDUP_LEN   = 1,
    parameter int PUNCH_LEN    = 2,
    parameter int X_BASE       = 20,
    parameter int X_STEP       = 40,
    parameter int Y_POS        = 8,
    parameter int START_LANE   = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [HEALTH_W-1:0] health,
    input  logic [LANE_W-1:0]   rand_bits,
    input  logic                hit_ack,
    input  logic                draw_done,
    output logic [LANE_W-1:0]   lane,
    output logic [7:0]          x_out,
    output logic [6:0]          y_out,
    output logic                aggressive,
    output logic                windup,
    output logic                punch,
    output logic                dead,
    output logic                move_pulse,
    output logic                draw_req
);
    import enemy_pkg::*;

    if (X_BASE + (NUM_LANES - 1) * X_STEP > 255) begin : g_x_range_check
        $error("enemy_ai: rightmost lane x does not fit in 8 bits");
    end

    localparam logic [7:0]        CALM_MOVES_C = 8'(CALM_MOVES);
    localparam logic [7:0]        AGGR_MOVES_C = 8'(AGGR_MOVES);
    localparam logic [7:0]        WINDUP_C     = 8'(WINDUP_LEN);
    localparam logic [7:0]        PUNCH_C      = 8'(PUNCH_LEN);
    localparam logic [TICK_W-1:0] CALM_LOAD    = TICK_W'(CALM_TICKS - 1);
    localparam logic [TICK_W-1:0] AGGR_LOAD    = TICK_W'(AGGR_TICKS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(NUM_LANES - 1);

    logic [2:0]          state, state_nxt;
    logic [7:0]          move_count, move_count_nxt;
    logic [7:0]          phase, phase_nxt;
    logic [LANE_W-1:0]   lane_nxt, cand, hop_lane;
    logic                move_nxt;
    logic                init_pend;
    logic                changed;
    logic                tick, tick_en;
    logic [TICK_W-1:0]   period;
    logic [7:0]          move_lim;
    mode_t               mode;
    int                  rand_val;

    assign aggressive = (mode == MODE_AGGR);
    assign windup     = (state == ST_WINDUP);
    assign punch      = (state == ST_PUNCH);
    assign dead       = (state == ST_DEAD);
    assign y_out      = 7'(Y_POS);

    assign period   = (mode == MODE_AGGR) ? AGGR_LOAD : CALM_LOAD;
    assign move_lim = (mode == MODE_AGGR) ? AGGR_MOVES_C : CALM_MOVES_C;
    // Ticks stall during a redraw so the drawer never misses a sprite change.
    assign tick_en  = enable && !draw_req;

    tick_gen #(
        .RESET_LOAD(CALM_TICKS - 1)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .enable(tick_en),
        .period(period),
        .tick  (tick)
    );

    // Fold out-of-range LFSR values back into the lane range; a repeat of the
    // current lane is bumped to the next one so every move is visible.
    always_comb begin
        rand_val = 32'(rand_bits);
        cand     = (rand_val < NUM_LANES) ? LANE_W'(rand_val) : LANE_W'(rand_val - NUM_LANES);
        hop_lane = cand;
        if (cand == lane) begin
            hop_lane = (lane == LAST_LANE) ? '0 : lane + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        move_count_nxt = move_count;
        phase_nxt      = phase;
        lane_nxt       = lane;
        move_nxt       = 1'b0;
        if (health == '0) begin
            state_nxt = ST_DEAD;
        end else if (enable) begin
            case (state)
                ST_MOVE: begin
                    if (tick) begin
                        if (move_count >= move_lim) begin
                            state_nxt      = ST_WINDUP;
                            move_count_nxt = '0;
                            phase_nxt      = '0;
                        end else begin
                            lane_nxt       = hop_lane;
                            move_count_nxt = move_count + 8'd1;
                            move_nxt       = 1'b1;
                        end
                    end
                end
                ST_WINDUP: begin
                    if (tick) begin
                        if (phase + 8'd1 >= WINDUP_C) begin
                            state_nxt = ST_PUNCH;
                            phase_nxt = '0;
                        end else begin
                            phase_nxt = phase + 8'd1;
                        end
                    end
                end
                ST_PUNCH: begin
                    if (hit_ack) begin
                        state_nxt = ST_RECOVER;
                        phase_nxt = '0;
                    end else if (tick) begin
                        if (phase + 8'd1 >= PUNCH_C) begin
                            state_nxt = ST_RECOVER;
                            phase_nxt = '0;
                        end else begin
                            phase_nxt = phase + 8'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (tick) begin
                        state_nxt = ST_MOVE;
                    end
                end
                ST_DEAD: begin
                    state_nxt = ST_DEAD;
                end
                default: begin
                    state_nxt = ST_MOVE;
                end
            endcase
        end
    end

    // Any visible sprite change requests a redraw on the edge it takes effect.
    assign changed = (lane_nxt != lane)
                   || ((state_nxt == ST_WINDUP) != windup)
                   || ((state_nxt == ST_PUNCH) != punch)
                   || ((state_nxt == ST_DEAD) != dead);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_MOVE;
            lane       <= LANE_W'(START_LANE);
            x_out      <= lane_to_x(START_LANE, X_BASE, X_STEP);
            mode       <= MODE_CALM;
            move_count <= '0;
            phase      <= '0;
            move_pulse <= 1'b0;
            draw_req   <= 1'b0;
            init_pend  <= 1'b1;
        end else begin
            state      <= state_nxt;
            lane       <= lane_nxt;
            x_out      <= lane_to_x(32'(lane_nxt), X_BASE, X_STEP);
            mode       <= ((32'(health) < AGGRO_THRESH) && (health != '0)) ? MODE_AGGR : MODE_CALM;
            move_count <= move_count_nxt;
            phase      <= phase_nxt;
            move_pulse <= move_nxt;
            draw_req   <= init_pend || changed || (draw_req && !draw_done);
            init_pend  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enemy_ai.sv
// Scoreboard bench for enemy_ai: expected lanes are queued as moves are
// provoked and compared when move_pulse fires; timing is checked in edges.
module tb_enemy_ai;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] health;
    logic [1:0] rand_bits;
    logic       hit_ack;
    logic       draw_done;
    logic [1:0] lane;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       aggressive, windup, punch, dead, move_pulse, draw_req;

    typedef struct {
        int lane;
        int x;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_lane;
    int   n;

    localparam int W_PULSE  = 0;
    localparam int W_WINDUP = 1;
    localparam int W_PUNCH  = 2;
    localparam int W_NOPUN  = 3;

    enemy_ai #(
        .NUM_LANES(3), .LANE_W(2), .HEALTH_W(4), .AGGRO_THRESH(6),
        .CALM_TICKS(4), .AGGR_TICKS(2), .CALM_MOVES(4), .AGGR_MOVES(2),
        .WINDUP_LEN(1), .PUNCH_LEN(2), .X_BASE(20), .X_STEP(40),
        .Y_POS(8), .START_LANE(0)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .health(health),
        .rand_bits(rand_bits), .hit_ack(hit_ack), .draw_done(draw_done),
        .lane(lane), .x_out(x_out), .y_out(y_out), .aggressive(aggressive),
        .windup(windup), .punch(punch), .dead(dead),
        .move_pulse(move_pulse), .draw_req(draw_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int next_lane(input int cur, input int r);
        int c;
        c = (r < 3) ? r : r - 3;
        if (c == cur) c = (cur == 2) ? 0 : cur + 1;
        return c;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_move(input int r);
        exp_t e;
        rand_bits = 2'(r);
        exp_lane  = next_lane(exp_lane, r);
        e.lane    = exp_lane;
        e.x       = 20 + 40 * exp_lane;
        sb_q.push_back(e);
    endtask

    task automatic wait_for(input int sel, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < 60) begin
            step();
            cnt++;
            case (sel)
                W_PULSE:  hit = move_pulse;
                W_WINDUP: hit = windup;
                W_PUNCH:  hit = punch;
                default:  hit = !punch;
            endcase
        end
        if (!hit) chk("wait_timeout", 0, 1);
    endtask

    task automatic move_and_check(input int r, input int exp_n, input string tag);
        int k;
        expect_move(r);
        wait_for(W_PULSE, k);
        chk(tag, k, exp_n);
        chk("draw_on_move", int'(draw_req), 1);
        step();
        chk("pulse_width", int'(move_pulse), 0);
    endtask

    always @(negedge clock) begin
        if (!reset && move_pulse) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_move", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_lane", int'(lane), e.lane);
                chk("sb_x", int'(x_out), e.x);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; health = 4'd10; rand_bits = 2'd2;
        hit_ack = 1'b0; draw_done = 1'b1; exp_lane = 0;
        step();
        step();
        chk("rst_lane", int'(lane), 0);
        chk("rst_x", int'(x_out), 20);
        chk("rst_y", int'(y_out), 8);
        chk("rst_aggr", int'(aggressive), 0);
        chk("rst_windup", int'(windup), 0);
        chk("rst_punch", int'(punch), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_pulse", int'(move_pulse), 0);
        chk("rst_draw", int'(draw_req), 0);
        reset = 1'b0;
        step();
        chk("init_draw", int'(draw_req), 1);

        // calm roaming: 0->2, 2->0 (wrap on repeat), 0->1, 1->2 (bump on repeat)
        move_and_check(2, 4, "calm_period_first");
        move_and_check(2, 4, "calm_period");
        move_and_check(1, 4, "calm_period");
        move_and_check(1, 4, "calm_period");

        wait_for(W_WINDUP, n);
        chk("calm_attack_delay", n, 4);
        chk("windup_lane_hold", int'(lane), exp_lane);
        chk("windup_draw", int'(draw_req), 1);
        wait_for(W_PUNCH, n);
        chk("windup_len", n, 5);
        chk("punch_clears_windup", int'(windup), 0);
        wait_for(W_NOPUN, n);
        chk("punch_timeout", n, 9);

        // rand=3 folds to lane 0, then a second calm attack ended by hit_ack
        move_and_check(3, 9, "recover_to_move");
        move_and_check(1, 4, "calm_period");
        move_and_check(0, 4, "calm_period");
        move_and_check(2, 4, "calm_period");
        wait_for(W_WINDUP, n);
        chk("calm_attack_delay2", n, 4);
        wait_for(W_PUNCH, n);
        chk("windup_len2", n, 5);
        hit_ack = 1'b1;
        step();
        chk("hit_ack_recover", int'(punch), 0);
        hit_ack = 1'b0;

        // drop into aggressive mode mid-count
        health = 4'd5;
        move_and_check(0, 7, "aggr_switch");
        chk("aggr_flag", int'(aggressive), 1);
        move_and_check(0, 2, "aggr_period");
        wait_for(W_WINDUP, n);
        chk("aggr_attack_delay", n, 2);
        wait_for(W_PUNCH, n);
        chk("aggr_windup_len", n, 3);

        // death beats a simultaneous hit_ack
        health = 4'd0;
        hit_ack = 1'b1;
        step();
        chk("dead_entry", int'(dead), 1);
        chk("dead_punch", int'(punch), 0);
        chk("dead_aggr", int'(aggressive), 0);
        hit_ack = 1'b0;
        enable = 1'b0;
        repeat (10) step();
        chk("dead_hold_disabled", int'(dead), 1);
        enable = 1'b1;
        health = 4'd10;
        repeat (20) step();
        chk("dead_sticky", int'(dead), 1);
        chk("dead_no_windup", int'(windup), 0);

        reset = 1'b1;
        step();
        chk("reset_clears_dead", int'(dead), 0);
        chk("reset_lane", int'(lane), 0);
        reset = 1'b0;
        exp_lane = 0;
        step();
        chk("init_draw2", int'(draw_req), 1);

        // stalled redraw freezes ticking
        expect_move(1);
        wait_for(W_PULSE, n);
        chk("post_reset_period", n, 4);
        draw_done = 1'b0;
        repeat (10) step();
        chk("draw_hold", int'(draw_req), 1);
        chk("draw_hold_lane", int'(lane), 1);
        expect_move(0);
        draw_done = 1'b1;
        step();
        chk("draw_release", int'(draw_req), 0);
        wait_for(W_PULSE, n);
        chk("resume_period", n, 4);
        step();

        // enable low holds the tick counter
        enable = 1'b0;
        repeat (6) step();
        enable = 1'b1;
        expect_move(2);
        wait_for(W_PULSE, n);
        chk("enable_freeze", n, 4);
        step();
        step();
        chk("sb_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
